// File: rtl/unit_output_arbiter_if.sv
// Bundle of the unit-side FWFT read ports and the merged downstream write port
// of the output arbiter. The arbiter takes the master view and the environment
// (unit buffers plus downstream FIFO) takes the slave view.
interface unit_output_arbiter_if #(
    parameter int N_UNITS = 4,
    parameter int WIDTH   = 16
);
    logic [N_UNITS*WIDTH-1:0] unit_dout;
    logic [N_UNITS-1:0]       unit_empty;
    logic [N_UNITS-1:0]       unit_rd_en;
    logic [WIDTH-1:0]         dout;
    logic                     wr_en;
    logic                     afull;
    logic                     pkt_done;
    logic [15:0]              pkt_count;
    logic [3:0]               cur_unit;

    modport master (
        input  unit_dout, unit_empty, afull,
        output unit_rd_en, dout, wr_en, pkt_done, pkt_count, cur_unit
    );

    modport slave (
        output unit_dout, unit_empty, afull,
        input  unit_rd_en, dout, wr_en, pkt_done, pkt_count, cur_unit
    );
endinterface

// File: rtl/unit_output_arbiter.sv
// Round-robin packet arbiter: merges fixed-length packets from N_UNITS
// first-word-fall-through unit buffers into one registered word stream.
// A started packet is always forwarded whole; source underrun or downstream
// almost-full only stalls it.
module unit_output_arbiter #(
    parameter int N_UNITS = 4,
    parameter int WIDTH   = 16,
    parameter int PKT_LEN = 8
) (
    input  logic CLK,
    input  logic rst,
    unit_output_arbiter_if.master bus
);
    localparam int SEL_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    localparam int CNT_W = $clog2(PKT_LEN);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PKT_LEN - 1);
    localparam logic [SEL_W-1:0] LAST_UNIT = SEL_W'(N_UNITS - 1);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_q;
    logic [SEL_W-1:0]   pick;
    logic [SEL_W-1:0]   rr_idx;
    logic               any_req;
    logic               pop;
    logic               last_pop;
    logic [CNT_W-1:0]   word_cnt_q;
    logic [WIDTH-1:0]   src_word;

    logic [WIDTH-1:0]   dout_p1;
    logic               wr_en_p1;
    logic               pkt_done_p1;
    logic [15:0]        pkt_count_r;

    // Round-robin search: first non-empty unit upward from last+1, wrapping.
    always_comb begin
        pick    = last_q;
        rr_idx  = '0;
        any_req = 1'b0;
        // Walk downward so the closest candidate (smallest offset) wins.
        for (int k = N_UNITS; k >= 1; k--) begin
            rr_idx = SEL_W'((int'(last_q) + k) % N_UNITS);
            if (!bus.unit_empty[rr_idx]) begin
                pick    = rr_idx;
                any_req = 1'b1;
            end
        end
    end

    // Word mux from the selected unit and its one-hot pop strobe.
    always_comb begin
        src_word       = '0;
        bus.unit_rd_en = '0;
        for (int u = 0; u < N_UNITS; u++) begin
            if (sel_q == SEL_W'(u)) begin
                src_word          = bus.unit_dout[u*WIDTH +: WIDTH];
                bus.unit_rd_en[u] = pop;
            end
        end
    end

    // Next-state logic; pops are suppressed during reset so no word is lost.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        pop      = 1'b0;
        last_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    sel_d   = pick;
                    state_d = XFER;
                end
            end
            XFER: begin
                pop      = !bus.unit_empty[sel_q] && !bus.afull && !rst;
                last_pop = pop && (word_cnt_q == LAST_WORD);
                if (last_pop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register, grant and round-robin pointer.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= LAST_UNIT;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            if (last_pop) begin
                last_q <= sel_q;
            end
        end
    end

    // Stage p1: popped word, write strobe, packet accounting.
    always_ff @(posedge CLK) begin
        if (rst) begin
            word_cnt_q  <= '0;
            dout_p1     <= '0;
            wr_en_p1    <= 1'b0;
            pkt_done_p1 <= 1'b0;
            pkt_count_r <= '0;
        end else begin
            wr_en_p1    <= pop;
            pkt_done_p1 <= last_pop;
            if (pop) begin
                dout_p1    <= src_word;
                word_cnt_q <= last_pop ? '0 : word_cnt_q + 1'b1;
            end
            if (last_pop) begin
                pkt_count_r <= pkt_count_r + 16'd1;
            end
        end
    end

    assign bus.dout      = dout_p1;
    assign bus.wr_en     = wr_en_p1;
    assign bus.pkt_done  = pkt_done_p1;
    assign bus.pkt_count = pkt_count_r;
    assign bus.cur_unit  = 4'(sel_q);

endmodule

// File: tb/tb_unit_output_arbiter.sv
// Directed bench for unit_output_arbiter: single packet timing, round-robin
// order, backpressure, source underrun, reset mid-packet and counter wrap.
module tb_unit_output_arbiter;
    logic CLK = 1'b0;
    logic rst = 1'b1;

    always #5 CLK = ~CLK;

    unit_output_arbiter_if #(.N_UNITS(4), .WIDTH(16)) bus ();
    unit_output_arbiter_if #(.N_UNITS(1), .WIDTH(16)) bus2 ();

    unit_output_arbiter #(.N_UNITS(4), .WIDTH(16), .PKT_LEN(8)) u_dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus.master)
    );

    unit_output_arbiter #(.N_UNITS(1), .WIDTH(16), .PKT_LEN(2)) u_dut2 (
        .CLK (CLK),
        .rst (rst),
        .bus (bus2.master)
    );

    // Unit buffer models: word i of unit u is {u, i}; wp grows as the bench loads.
    logic [15:0] mem [4][128];
    int rp [4];
    int wp [4];
    int cyc;
    int checks = 0;
    int fails  = 0;

    // FWFT view of each unit buffer.
    always_comb begin
        bus.unit_dout  = '0;
        bus.unit_empty = '1;
        for (int u = 0; u < 4; u++) begin
            bus.unit_dout[u*16 +: 16] = mem[u][rp[u] % 128];
            bus.unit_empty[u]         = (rp[u] >= wp[u]);
        end
    end

    // Pops advance the read pointers; cycle counter for throughput.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        for (int u = 0; u < 4; u++) begin
            if (bus.unit_rd_en[u]) rp[u] <= rp[u] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Consume n written words of unit u starting at buffer index first.
    task automatic expect_words(input int u, input int first, input int n, input bit ends_pkt);
        for (int k = 0; k < n; k++) begin
            int waited;
            waited = 0;
            @(negedge CLK);
            while (bus.wr_en !== 1'b1 && waited < 30) begin
                @(negedge CLK);
                waited++;
            end
            chk("word_seen", {31'd0, bus.wr_en === 1'b1}, 32'd1);
            if (bus.wr_en !== 1'b1) return;
            chk("dout", {16'd0, bus.dout}, (u << 8) | (first + k));
            chk("cur_unit", {28'd0, bus.cur_unit}, u);
            chk("pkt_done", {31'd0, bus.pkt_done}, (ends_pkt && k == n - 1) ? 1 : 0);
        end
    endtask

    initial begin
        int t0;
        int nxt;
        int done_cnt;
        bit prev_pop;
        int waited;

        for (int u = 0; u < 4; u++) begin
            rp[u] = 0;
            wp[u] = 0;
            for (int i = 0; i < 128; i++) mem[u][i] = 16'((u << 8) | i);
        end
        bus.afull        = 1'b0;
        bus2.afull       = 1'b0;
        bus2.unit_empty  = 1'b1;
        bus2.unit_dout   = 16'hABCD;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_dout", {16'd0, bus.dout}, 0);
        chk("rst_wr_en", {31'd0, bus.wr_en}, 0);
        chk("rst_pkt_done", {31'd0, bus.pkt_done}, 0);
        chk("rst_pkt_count", {16'd0, bus.pkt_count}, 0);
        chk("rst_cur_unit", {28'd0, bus.cur_unit}, 0);
        chk("rst_rd_en", {28'd0, bus.unit_rd_en}, 0);
        rst = 1'b0;
        @(negedge CLK);
        chk("idle_rd_en", {28'd0, bus.unit_rd_en}, 0);

        // Single unit: unit 2, words 0x0200..0x0207
        wp[2] = 8;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            chk("t1_rd_en", {28'd0, bus.unit_rd_en}, (c >= 1 && c <= 8) ? 4 : 0);
            chk("t1_wr_en", {31'd0, bus.wr_en}, (c >= 2 && c <= 9) ? 1 : 0);
            if (c >= 2 && c <= 9) chk("t1_dout", {16'd0, bus.dout}, 32'h0200 + c - 2);
            chk("t1_pkt_done", {31'd0, bus.pkt_done}, (c == 9) ? 1 : 0);
        end
        chk("t1_pkt_count", {16'd0, bus.pkt_count}, 1);

        // Round-robin: two packets in every unit, fresh pointer after reset
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        wp[0] = 16; wp[1] = 16; wp[2] = 24; wp[3] = 16;
        t0 = cyc;
        for (int r = 0; r < 2; r++) begin
            for (int u = 0; u < 4; u++) begin
                expect_words(u, ((u == 2) ? 8 : 0) + r * 8, 8, 1'b1);
            end
        end
        chk("rr_cycles", cyc - t0, 72);
        chk("rr_pkt_count", {16'd0, bus.pkt_count}, 8);

        // Backpressure: afull toggles every cycle on unit 0 (words 16..23)
        wp[0] = 24;
        bus.afull = 1'b1;
        nxt = 0;
        done_cnt = 0;
        prev_pop = 1'b0;
        for (int it = 0; it < 60 && nxt < 8; it++) begin
            @(negedge CLK);
            if (bus.wr_en === 1'b1) begin
                chk("bp_write_follows_pop", {31'd0, prev_pop}, 1);
                chk("bp_dout", {16'd0, bus.dout}, 16 + nxt);
                nxt++;
            end
            if (bus.pkt_done === 1'b1) done_cnt++;
            bus.afull = ~bus.afull;
            #1;
            prev_pop = |bus.unit_rd_en;
            if (bus.afull) chk("bp_no_pop_afull", {28'd0, bus.unit_rd_en}, 0);
        end
        bus.afull = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            chk("bp_tail_wr_en", {31'd0, bus.wr_en}, 0);
            if (bus.pkt_done === 1'b1) done_cnt++;
        end
        chk("bp_word_total", nxt, 8);
        chk("bp_pkt_done_once", done_cnt, 1);

        // Underrun: unit 1 has only 4 words for a while; unit 3 must wait
        wp[1] = 20;
        wp[3] = 24;
        expect_words(1, 16, 4, 1'b0);
        for (int g = 0; g < 5; g++) begin
            @(negedge CLK);
            chk("ur_gap_wr_en", {31'd0, bus.wr_en}, 0);
            chk("ur_gap_cur_unit", {28'd0, bus.cur_unit}, 1);
            chk("ur_gap_rd_en", {28'd0, bus.unit_rd_en}, 0);
        end
        wp[1] = 24;
        expect_words(1, 20, 4, 1'b1);
        expect_words(3, 16, 8, 1'b1);

        // Reset mid-packet on unit 0 after its fourth word
        wp[0] = 32;
        expect_words(0, 24, 4, 1'b0);
        rst = 1'b1;
        @(negedge CLK);
        chk("mr_dout", {16'd0, bus.dout}, 0);
        chk("mr_wr_en", {31'd0, bus.wr_en}, 0);
        chk("mr_pkt_done", {31'd0, bus.pkt_done}, 0);
        chk("mr_pkt_count", {16'd0, bus.pkt_count}, 0);
        chk("mr_cur_unit", {28'd0, bus.cur_unit}, 0);
        chk("mr_rd_en", {28'd0, bus.unit_rd_en}, 0);
        rst = 1'b0;
        expect_words(0, 28, 4, 1'b0);
        wp[0] = 36;
        expect_words(0, 32, 4, 1'b1);
        chk("mr_pkt_count_after", {16'd0, bus.pkt_count}, 1);

        // Counter wrap on the PKT_LEN=2 single-unit instance
        force u_dut2.pkt_count_r = 16'hFFFE;
        @(negedge CLK);
        release u_dut2.pkt_count_r;
        @(negedge CLK);
        chk("wrap_preload", {16'd0, bus2.pkt_count}, 32'hFFFE);
        bus2.unit_empty = 1'b0;
        for (int p = 0; p < 2; p++) begin
            waited = 0;
            @(negedge CLK);
            while (bus2.pkt_done !== 1'b1 && waited < 10) begin
                @(negedge CLK);
                waited++;
            end
            if (p == 1) bus2.unit_empty = 1'b1;
            chk("wrap_pkt_done_seen", {31'd0, bus2.pkt_done === 1'b1}, 1);
            chk("wrap_dout", {16'd0, bus2.dout}, 32'hABCD);
            chk("wrap_pkt_count", {16'd0, bus2.pkt_count}, (p == 0) ? 32'hFFFF : 32'h0000);
        end
        bus2.unit_empty = 1'b1;

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
